// File: rtl/operand_fetch_stage_pkg.sv
// rtl/operand_fetch_stage_pkg.sv - shared FSM encodings and register-file address layout
package operand_fetch_stage_pkg;

  localparam int SRC_W = 4;
  localparam int N_CH  = 16;

  // rd_addr layout: {block index (zero for channel registers), source index[SRC_W-1:0]}
  localparam int RD_ADDR_SRC_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_READ  = 2'd2,
    S_OUT   = 2'd3
  } ofs_state_e;

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// rtl/operand_fetch_stage_scoreboard.sv - channel/accumulator pending-write scoreboard
module operand_scoreboard
  import operand_fetch_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  set_en,
  input  logic                  set_ch,
  input  logic [SRC_W-1:0]      set_ch_idx,
  input  logic                  set_acc,
  input  logic                  wb_ch_valid,
  input  logic [SRC_W-1:0]      wb_ch_dest,
  input  logic                  wb_acc_valid,
  input  logic [2:0][SRC_W-1:0] src,
  input  logic [2:0]            src_reg,
  input  logic [2:0]            needed,
  input  logic                  acc_needed,
  output logic                  hazard
);

  logic [N_CH-1:0] pend_ch_q, pend_ch_d;
  logic            pend_acc_q, pend_acc_d;

  // Clears are applied first so that a same-cycle set on the same entry wins.
  always_comb begin
    pend_ch_d  = pend_ch_q;
    pend_acc_d = pend_acc_q;
    if (wb_ch_valid)       pend_ch_d[wb_ch_dest] = 1'b0;
    if (wb_acc_valid)      pend_acc_d            = 1'b0;
    if (set_en && set_ch)  pend_ch_d[set_ch_idx] = 1'b1;
    if (set_en && set_acc) pend_acc_d            = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_ch_q  <= '0;
      pend_acc_q <= 1'b0;
    end else begin
      pend_ch_q  <= pend_ch_d;
      pend_acc_q <= pend_acc_d;
    end
  end

  // Block-register sources are never tracked, so they cannot raise a hazard.
  always_comb begin
    hazard = acc_needed & pend_acc_q;
    for (int i = 0; i < 3; i++) begin
      hazard = hazard | (needed[i] & ~src_reg[i] & pend_ch_q[src[i]]);
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch stage: hazard check, register read, execute handoff
// Optional stall counter output enabled by OPERAND_FETCH_STALL_COUNT_EN.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int data_width = 16,
  parameter int n_blocks   = 256,
  parameter int ctrl_width = 48,
  localparam int BW        = $clog2(n_blocks)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BW-1:0]         in_block,
  input  logic [SRC_W-1:0]      in_src_a,
  input  logic [SRC_W-1:0]      in_src_b,
  input  logic [SRC_W-1:0]      in_src_c,
  input  logic                  in_src_a_reg,
  input  logic                  in_src_b_reg,
  input  logic                  in_src_c_reg,
  input  logic                  in_arg_a_needed,
  input  logic                  in_arg_b_needed,
  input  logic                  in_arg_c_needed,
  input  logic                  in_acc_needed,
  input  logic [SRC_W-1:0]      in_dest,
  input  logic                  in_writes_channel,
  input  logic                  in_writes_acc,
  input  logic [ctrl_width-1:0] in_ctrl,
  output logic [BW+SRC_W-1:0]   rd_addr_a,
  output logic [BW+SRC_W-1:0]   rd_addr_b,
  output logic [BW+SRC_W-1:0]   rd_addr_c,
  output logic                  rd_blk_a,
  output logic                  rd_blk_b,
  output logic                  rd_blk_c,
  input  logic [data_width-1:0] rd_data_a,
  input  logic [data_width-1:0] rd_data_b,
  input  logic [data_width-1:0] rd_data_c,
  input  logic                  wb_ch_valid,
  input  logic [SRC_W-1:0]      wb_ch_dest,
  input  logic                  wb_acc_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BW-1:0]         out_block,
  output logic [SRC_W-1:0]      out_dest,
  output logic [ctrl_width-1:0] out_ctrl,
  output logic [data_width-1:0] out_a,
  output logic [data_width-1:0] out_b,
  output logic [data_width-1:0] out_c,
  output logic                  out_writes_channel,
  output logic                  out_writes_acc,
  input  logic                  sample_tick
`ifdef OPERAND_FETCH_STALL_COUNT_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);

  ofs_state_e state_q, state_d;
  logic       latch, issue, capture, drain, hazard;

  logic [BW-1:0]           blk_q;
  logic [2:0][SRC_W-1:0]   src_q;
  logic [2:0]              src_reg_q;
  logic [2:0]              need_q;
  logic                    acc_need_q;
  logic [SRC_W-1:0]        dest_q;
  logic                    wch_q, wacc_q;
  logic [ctrl_width-1:0]   ctrl_q;

  logic                    out_valid_q;
  logic [BW-1:0]           out_block_q;
  logic [SRC_W-1:0]        out_dest_q;
  logic [ctrl_width-1:0]   out_ctrl_q;
  logic [data_width-1:0]   out_a_q, out_b_q, out_c_q;
  logic                    out_wch_q, out_wacc_q;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    latch    = 1'b0;
    issue    = 1'b0;
    capture  = 1'b0;
    drain    = 1'b0;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            latch   = 1'b1;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (!hazard) begin
            issue   = 1'b1;
            state_d = S_READ;
          end
        end
        S_READ: begin
          capture = 1'b1;
          state_d = S_OUT;
        end
        S_OUT: begin
          in_ready = out_ready;
          if (out_ready) begin
            drain = 1'b1;
            if (in_valid) begin
              latch   = 1'b1;
              state_d = S_CHECK;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_q      <= '0;
      src_q      <= '0;
      src_reg_q  <= '0;
      need_q     <= '0;
      acc_need_q <= 1'b0;
      dest_q     <= '0;
      wch_q      <= 1'b0;
      wacc_q     <= 1'b0;
      ctrl_q     <= '0;
    end else if (latch) begin
      blk_q      <= in_block;
      src_q      <= {in_src_c, in_src_b, in_src_a};
      src_reg_q  <= {in_src_c_reg, in_src_b_reg, in_src_a_reg};
      need_q     <= {in_arg_c_needed, in_arg_b_needed, in_arg_a_needed};
      acc_need_q <= in_acc_needed;
      dest_q     <= in_dest;
      wch_q      <= in_writes_channel;
      wacc_q     <= in_writes_acc;
      ctrl_q     <= in_ctrl;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_block_q <= '0;
      out_dest_q  <= '0;
      out_ctrl_q  <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      out_wch_q   <= 1'b0;
      out_wacc_q  <= 1'b0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      out_block_q <= blk_q;
      out_dest_q  <= dest_q;
      out_ctrl_q  <= ctrl_q;
      out_a_q     <= need_q[0] ? rd_data_a : '0;
      out_b_q     <= need_q[1] ? rd_data_b : '0;
      out_c_q     <= need_q[2] ? rd_data_c : '0;
      out_wch_q   <= wch_q;
      out_wacc_q  <= wacc_q;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end

  // Addresses come straight from the latched instruction, so the register
  // file samples them at the end of S_CHECK and returns data during S_READ.
  assign rd_addr_a = {src_reg_q[0] ? blk_q : {BW{1'b0}}, src_q[0]};
  assign rd_addr_b = {src_reg_q[1] ? blk_q : {BW{1'b0}}, src_q[1]};
  assign rd_addr_c = {src_reg_q[2] ? blk_q : {BW{1'b0}}, src_q[2]};
  assign rd_blk_a  = src_reg_q[0];
  assign rd_blk_b  = src_reg_q[1];
  assign rd_blk_c  = src_reg_q[2];

  assign out_valid          = out_valid_q;
  assign out_block          = out_block_q;
  assign out_dest           = out_dest_q;
  assign out_ctrl           = out_ctrl_q;
  assign out_a              = out_a_q;
  assign out_b              = out_b_q;
  assign out_c              = out_c_q;
  assign out_writes_channel = out_wch_q;
  assign out_writes_acc     = out_wacc_q;

  operand_scoreboard u_scoreboard (
    .clk          (clk),
    .reset_n      (reset_n),
    .set_en       (issue),
    .set_ch       (wch_q),
    .set_ch_idx   (dest_q),
    .set_acc      (wacc_q),
    .wb_ch_valid  (wb_ch_valid),
    .wb_ch_dest   (wb_ch_dest),
    .wb_acc_valid (wb_acc_valid),
    .src          (src_q),
    .src_reg      (src_reg_q),
    .needed       (need_q),
    .acc_needed   (acc_need_q),
    .hazard       (hazard)
  );

`ifdef OPERAND_FETCH_STALL_COUNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (sample_tick) begin
      stall_q <= '0;
    end else if (enable && (state_q == S_CHECK) && hazard && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  logic unused_sample_tick;
  assign unused_sample_tick = sample_tick;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - directed table and sequence bench for operand_fetch_stage
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n, enable, in_valid, in_ready;
  logic [7:0]  in_block;
  logic [3:0]  in_src_a, in_src_b, in_src_c, in_dest;
  logic        in_src_a_reg, in_src_b_reg, in_src_c_reg;
  logic        in_arg_a_needed, in_arg_b_needed, in_arg_c_needed, in_acc_needed;
  logic        in_writes_channel, in_writes_acc;
  logic [47:0] in_ctrl;
  logic [11:0] rd_addr_a, rd_addr_b, rd_addr_c;
  logic        rd_blk_a, rd_blk_b, rd_blk_c;
  logic [15:0] rd_data_a, rd_data_b, rd_data_c;
  logic        wb_ch_valid, wb_acc_valid;
  logic [3:0]  wb_ch_dest;
  logic        out_valid, out_ready;
  logic [7:0]  out_block;
  logic [3:0]  out_dest;
  logic [47:0] out_ctrl;
  logic [15:0] out_a, out_b, out_c;
  logic        out_writes_channel, out_writes_acc;
  logic        sample_tick;
`ifdef OPERAND_FETCH_STALL_COUNT_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_src_c(in_src_c),
    .in_src_a_reg(in_src_a_reg), .in_src_b_reg(in_src_b_reg), .in_src_c_reg(in_src_c_reg),
    .in_arg_a_needed(in_arg_a_needed), .in_arg_b_needed(in_arg_b_needed),
    .in_arg_c_needed(in_arg_c_needed), .in_acc_needed(in_acc_needed),
    .in_dest(in_dest), .in_writes_channel(in_writes_channel), .in_writes_acc(in_writes_acc),
    .in_ctrl(in_ctrl),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .rd_blk_a(rd_blk_a), .rd_blk_b(rd_blk_b), .rd_blk_c(rd_blk_c),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c),
    .wb_ch_valid(wb_ch_valid), .wb_ch_dest(wb_ch_dest), .wb_acc_valid(wb_acc_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_dest(out_dest), .out_ctrl(out_ctrl),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .out_writes_channel(out_writes_channel), .out_writes_acc(out_writes_acc),
    .sample_tick(sample_tick)
`ifdef OPERAND_FETCH_STALL_COUNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic [7:0]  blk;
    logic [3:0]  sa, sb, sc;
    logic [2:0]  sreg;
    logic [2:0]  need;
    logic        acc;
    logic [3:0]  dest;
    logic        wch, wacc;
    logic [47:0] ctrl;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic [15:0] da, db, dc;
    logic [11:0] ea, eb, ec;
    logic [2:0]  eblk;
    logic [15:0] oa, ob, oc;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [7:0] blk, input logic [3:0] sa, input logic [3:0] sb,
                                input logic [3:0] sc, input logic [2:0] sreg, input logic [2:0] need,
                                input logic acc, input logic [3:0] dest, input logic wch,
                                input logic wacc, input logic [47:0] ctrl);
    instr_t x;
    x.blk = blk; x.sa = sa; x.sb = sb; x.sc = sc; x.sreg = sreg; x.need = need;
    x.acc = acc; x.dest = dest; x.wch = wch; x.wacc = wacc; x.ctrl = ctrl;
    return x;
  endfunction

  task automatic set_in(input instr_t x);
    in_block = x.blk; in_src_a = x.sa; in_src_b = x.sb; in_src_c = x.sc;
    {in_src_c_reg, in_src_b_reg, in_src_a_reg} = x.sreg;
    {in_arg_c_needed, in_arg_b_needed, in_arg_a_needed} = x.need;
    in_acc_needed = x.acc; in_dest = x.dest;
    in_writes_channel = x.wch; in_writes_acc = x.wacc; in_ctrl = x.ctrl;
  endtask

  // Single instruction from IDLE with a clean scoreboard path; drains to IDLE.
  task automatic run_single(input instr_t r, input logic [15:0] da, input logic [15:0] exp_a,
                            input string name);
    set_in(r); rd_data_a = da; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    chk({name, "_chk_valid"}, out_valid, 1'b0);
    @(negedge clk);
    chk({name, "_read_valid"}, out_valid, 1'b0);
    @(negedge clk);
    chk({name, "_out_valid"}, out_valid, 1'b1);
    chk({name, "_out_a"}, out_a, exp_a);
    @(negedge clk);
  endtask

  // Writer issues, then a reader depending on it stalls n cycles until writeback.
  task automatic writer_reader(input instr_t w, input instr_t r, input logic is_acc,
                               input logic wb_at_issue, input int n, input logic [15:0] da,
                               input string name);
    set_in(w); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    if (wb_at_issue) begin
      wb_ch_valid = 1'b1; wb_ch_dest = w.dest;
    end
    @(negedge clk);
    wb_ch_valid = 1'b0;
    @(negedge clk);
    chk({name, "_w_valid"}, out_valid, 1'b1);
    chk({name, "_w_wch"}, out_writes_channel, w.wch);
    chk({name, "_w_wacc"}, out_writes_acc, w.wacc);
    set_in(r); rd_data_a = da; in_valid = 1'b1; sample_tick = 1'b1;
    @(negedge clk); in_valid = 1'b0; sample_tick = 1'b0;
    chk({name, "_r_in_ready"}, in_ready, 1'b0);
    for (int i = 1; i <= n; i++) begin
      if (i > 1) @(negedge clk);
      chk({name, "_stall"}, out_valid, 1'b0);
      if (i == n) begin
        if (is_acc) wb_acc_valid = 1'b1;
        else begin wb_ch_valid = 1'b1; wb_ch_dest = w.dest; end
      end
    end
    @(negedge clk);
    wb_ch_valid = 1'b0; wb_acc_valid = 1'b0;
    chk({name, "_release_chk"}, out_valid, 1'b0);
`ifdef OPERAND_FETCH_STALL_COUNT_EN
    chk({name, "_stall_cycles"}, stall_cycles, n);
`endif
    @(negedge clk);
    chk({name, "_release_read"}, out_valid, 1'b0);
    @(negedge clk);
    chk({name, "_r_valid"}, out_valid, 1'b1);
    chk({name, "_r_out_a"}, out_a, da);
    @(negedge clk);
`ifdef OPERAND_FETCH_STALL_COUNT_EN
    sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    chk({name, "_stall_tick_clear"}, stall_cycles, 16'd0);
`endif
  endtask

  vec_t   vecs[4];
  instr_t w, r;

  initial begin
    vecs[0].ins = mk(8'h03, 4'h2, 4'h1, 4'h4, 3'b010, 3'b011, 1'b0, 4'h6, 1'b0, 1'b0, 48'h0000_1111_2222);
    vecs[0].da = 16'h1234; vecs[0].db = 16'h0F0F; vecs[0].dc = 16'hBEEF;
    vecs[0].ea = 12'h002;  vecs[0].eb = 12'h031;  vecs[0].ec = 12'h004; vecs[0].eblk = 3'b010;
    vecs[0].oa = 16'h1234; vecs[0].ob = 16'h0F0F; vecs[0].oc = 16'h0000;

    vecs[1].ins = mk(8'hA5, 4'hF, 4'h0, 4'h9, 3'b101, 3'b111, 1'b0, 4'hB, 1'b0, 1'b0, 48'hDEAD_BEEF_0001);
    vecs[1].da = 16'h1111; vecs[1].db = 16'h2222; vecs[1].dc = 16'h3333;
    vecs[1].ea = 12'hA5F;  vecs[1].eb = 12'h000;  vecs[1].ec = 12'hA59; vecs[1].eblk = 3'b101;
    vecs[1].oa = 16'h1111; vecs[1].ob = 16'h2222; vecs[1].oc = 16'h3333;

    vecs[2].ins = mk(8'hFF, 4'h3, 4'h7, 4'hC, 3'b110, 3'b000, 1'b0, 4'h0, 1'b0, 1'b0, 48'hFFFF_FFFF_FFFF);
    vecs[2].da = 16'h5555; vecs[2].db = 16'h6666; vecs[2].dc = 16'h7777;
    vecs[2].ea = 12'h003;  vecs[2].eb = 12'hFF7;  vecs[2].ec = 12'hFFC; vecs[2].eblk = 3'b110;
    vecs[2].oa = 16'h0000; vecs[2].ob = 16'h0000; vecs[2].oc = 16'h0000;

    vecs[3].ins = mk(8'h00, 4'h1, 4'hE, 4'h5, 3'b001, 3'b101, 1'b0, 4'hF, 1'b0, 1'b0, 48'h8000_0000_0001);
    vecs[3].da = 16'hAAAA; vecs[3].db = 16'hBBBB; vecs[3].dc = 16'hCCCC;
    vecs[3].ea = 12'h001;  vecs[3].eb = 12'h00E;  vecs[3].ec = 12'h005; vecs[3].eblk = 3'b001;
    vecs[3].oa = 16'hAAAA; vecs[3].ob = 16'h0000; vecs[3].oc = 16'hCCCC;

    reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sample_tick = 1'b0;
    wb_ch_valid = 1'b0; wb_ch_dest = 4'h0; wb_acc_valid = 1'b0;
    rd_data_a = 16'h0; rd_data_b = 16'h0; rd_data_c = 16'h0;
    set_in(vecs[0].ins);

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rd_addr_b", rd_addr_b, 12'h000);
    chk("rst_rd_blk", {rd_blk_c, rd_blk_b, rd_blk_a}, 3'b000);
    chk("rst_out_a", out_a, 16'h0000);
    chk("rst_out_ctrl", out_ctrl, 48'h0);
`ifdef OPERAND_FETCH_STALL_COUNT_EN
    chk("rst_stall_cycles", stall_cycles, 16'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      set_in(vecs[i].ins);
      rd_data_a = vecs[i].da; rd_data_b = vecs[i].db; rd_data_c = vecs[i].dc;
      in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      chk("vec_rd_addr_a", rd_addr_a, vecs[i].ea);
      chk("vec_rd_addr_b", rd_addr_b, vecs[i].eb);
      chk("vec_rd_addr_c", rd_addr_c, vecs[i].ec);
      chk("vec_rd_blk", {rd_blk_c, rd_blk_b, rd_blk_a}, vecs[i].eblk);
      chk("vec_chk_valid", out_valid, 1'b0);
      @(negedge clk);
      chk("vec_read_valid", out_valid, 1'b0);
      @(negedge clk);
      chk("vec_out_valid", out_valid, 1'b1);
      chk("vec_out_a", out_a, vecs[i].oa);
      chk("vec_out_b", out_b, vecs[i].ob);
      chk("vec_out_c", out_c, vecs[i].oc);
      chk("vec_out_block", out_block, vecs[i].ins.blk);
      chk("vec_out_dest", out_dest, vecs[i].ins.dest);
      chk("vec_out_ctrl", out_ctrl, vecs[i].ins.ctrl);
      chk("vec_out_writes", {out_writes_acc, out_writes_channel}, 2'b00);
      @(negedge clk);
    end

    // Backpressure: outputs hold, no accept, next instruction taken as out_ready rises.
    out_ready = 1'b0;
    set_in(vecs[0].ins);
    rd_data_a = vecs[0].da; rd_data_b = vecs[0].db; rd_data_c = vecs[0].dc;
    in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_first_valid", out_valid, 1'b1);
    set_in(vecs[1].ins);
    rd_data_a = vecs[1].da; rd_data_b = vecs[1].db; rd_data_c = vecs[1].dc;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_a", out_a, 16'h1234);
      chk("bp_hold_b", out_b, 16'h0F0F);
      chk("bp_hold_ctrl", out_ctrl, 48'h0000_1111_2222);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    chk("bp_next_drained", out_valid, 1'b0);
    chk("bp_next_rd_addr_a", rd_addr_a, 12'hA5F);
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_valid", out_valid, 1'b1);
    chk("bp_next_a", out_a, 16'h1111);
    chk("bp_next_c", out_c, 16'h3333);
    @(negedge clk);

    // Enable low in S_CHECK freezes the pipeline.
    set_in(vecs[2].ins); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("en_freeze_valid", out_valid, 1'b0);
      chk("en_freeze_in_ready", in_ready, 1'b0);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("en_resume_read", out_valid, 1'b0);
    @(negedge clk);
    chk("en_resume_valid", out_valid, 1'b1);
    @(negedge clk);

    // Channel RAW hazard: ch 5 written, then read.
    w = mk(8'h01, 4'h0, 4'h0, 4'h0, 3'b000, 3'b000, 1'b0, 4'h5, 1'b1, 1'b0, 48'h1);
    r = mk(8'h02, 4'h5, 4'h0, 4'h0, 3'b000, 3'b001, 1'b0, 4'h1, 1'b0, 1'b0, 48'h2);
    writer_reader(w, r, 1'b0, 1'b0, 10, 16'h5A5A, "raw_ch5");

    // Accumulator hazard; the block-register source alone would not stall.
    w = mk(8'h01, 4'h0, 4'h0, 4'h0, 3'b000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 48'h3);
    r = mk(8'h06, 4'h3, 4'h0, 4'h0, 3'b001, 3'b001, 1'b1, 4'h2, 1'b0, 1'b0, 48'h4);
    writer_reader(w, r, 1'b1, 1'b0, 3, 16'hC3C3, "raw_acc");

    // Writeback to ch 7 in the same cycle ch 7 is claimed: claim must survive.
    w = mk(8'h01, 4'h0, 4'h0, 4'h0, 3'b000, 3'b000, 1'b0, 4'h7, 1'b1, 1'b0, 48'h5);
    r = mk(8'h02, 4'h7, 4'h0, 4'h0, 3'b000, 3'b001, 1'b0, 4'h1, 1'b0, 1'b0, 48'h6);
    writer_reader(w, r, 1'b0, 1'b1, 5, 16'h7777, "set_wins_ch7");

    // Block-register read of index 2 while channel 2 is pending does not stall.
    run_single(mk(8'h01, 4'h0, 4'h0, 4'h0, 3'b000, 3'b000, 1'b0, 4'h2, 1'b1, 1'b0, 48'h7),
               16'h0000, 16'h0000, "blk_writer");
    run_single(mk(8'h09, 4'h2, 4'h0, 4'h0, 3'b001, 3'b001, 1'b0, 4'h3, 1'b0, 1'b0, 48'h8),
               16'h9292, 16'h9292, "blk_no_stall");

    // Reset during S_READ wipes outputs and the ch 9 claim.
    set_in(mk(8'h04, 4'h1, 4'h2, 4'h3, 3'b111, 3'b111, 1'b0, 4'h9, 1'b1, 1'b0, 48'h9));
    in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_rd_addr_b", rd_addr_b, 12'h000);
    chk("rst_mid_rd_blk", {rd_blk_c, rd_blk_b, rd_blk_a}, 3'b000);
    chk("rst_mid_out_a", out_a, 16'h0000);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("rst_mid_hold_valid", out_valid, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    run_single(mk(8'h05, 4'h9, 4'h0, 4'h0, 3'b000, 3'b001, 1'b0, 4'h4, 1'b0, 1'b0, 48'hA),
               16'h4321, 16'h4321, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Sits directly downstream of instruction fetch/decode.
- Accepts one decoded instruction per handshake and holds it until all needed source operands are hazard-free.
- Reads up to three operands from the channel/block register file, then presents instruction plus operand values to the execute stage.
- Owns the channel-register and accumulator write scoreboard; writeback clears entries.

Parameters:
- data_width, 16, operand width
- n_blocks, 256, block count; BW = $clog2(n_blocks)
- ctrl_width, 48, opaque decoded-control bundle carried unchanged to execute

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  global stage enable; when low all state holds
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage can accept
- in_block  in  BW  block index
- in_src_a / in_src_b / in_src_c  in  4 each  source indices
- in_src_a_reg / in_src_b_reg / in_src_c_reg  in  1 each  1 = block register, 0 = channel register
- in_arg_a_needed / in_arg_b_needed / in_arg_c_needed  in  1 each  operand used
- in_acc_needed  in  1  reads accumulator
- in_dest  in  4  destination channel register
- in_writes_channel / in_writes_acc  in  1 each  write intent
- in_ctrl  in  ctrl_width  pass-through control
- rd_addr_a / rd_addr_b / rd_addr_c  out  BW+4 each  register-file address: {block,src} if block reg, else {0,src}
- rd_blk_a / rd_blk_b / rd_blk_c  out  1 each  selects block-register bank
- rd_data_a / rd_data_b / rd_data_c  in  data_width each  read data, valid one cycle after address
- wb_ch_valid  in  1  channel writeback
- wb_ch_dest  in  4  written channel register
- wb_acc_valid  in  1  accumulator writeback
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts
- out_block  out  BW  block index
- out_dest  out  4  destination register
- out_ctrl  out  ctrl_width  pass-through control
- out_a / out_b / out_c  out  data_width each  operand values
- out_writes_channel / out_writes_acc  out  1 each  write intent
- sample_tick  in  1  sample boundary

Behaviour:
- Reset (async, reset_n = 0): state = S_IDLE; out_valid = 0; all out_* data = 0; rd_addr_* = 0; rd_blk_* = 0; scoreboard pend_ch[15:0] = 0; pend_acc = 0. Deassertion takes effect on the next clk edge.
- FSM, advancing only when enable = 1:
  - S_IDLE: in_ready = 1. On in_valid, latch all in_* fields; go to S_CHECK.
  - S_CHECK: hazard = OR over x of (arg_x_needed & !src_x_reg & pend_ch[src_x]), OR (acc_needed & pend_acc). Uses registered scoreboard values only.
    - If hazard: stay in S_CHECK.
    - If no hazard: drive rd_addr_* and rd_blk_*; set pend_ch[dest] if writes_channel; set pend_acc if writes_acc; go to S_READ.
  - S_READ: capture out_x = arg_x_needed ? rd_data_x : 0; copy block, dest, ctrl and write flags to outputs; out_valid = 1; go to S_OUT.
  - S_OUT: in_ready = out_ready. On out_ready, clear out_valid. If in_valid is also high, latch the new instruction and go to S_CHECK; otherwise go to S_IDLE.
- Minimum latency: 2 cycles from accept to out_valid. Throughput: one instruction per 3 cycles.
- Writeback: wb_ch_valid clears pend_ch[wb_ch_dest]; wb_acc_valid clears pend_acc. If a clear and a set hit the same bit in the same cycle, set wins.
- A clear visible in S_CHECK takes effect next cycle, giving one extra stall. No bypass path is required.
- out_* must not change while out_valid = 1 and out_ready = 0.
- Block-register sources never stall.
- sample_tick does not touch the scoreboard.
- enable = 0 freezes state, outputs and scoreboard; writeback clears are still applied.

Optional Feature:
- Macro: OPERAND_FETCH_STALL_COUNT_EN.
- When defined: adds output stall_cycles [15:0]. It increments on each enabled cycle spent in S_CHECK with hazard = 1, saturates at 16'hFFFF, clears on sample_tick (clear wins over increment), and resets to 0.
- When undefined: no port and no counter logic.

Decomposition:
- Shared package/header: FSM state encodings (S_IDLE, S_CHECK, S_READ, S_OUT) and the rd_addr packing width/layout constant.
- Natural sub-module: operand_scoreboard (pend_ch, pend_acc, set/clear priority, hazard output).

Test Plan:
- Hazard-free MAC, block 3, src_a = 2 (channel), src_b = 1 (block reg), rd_data = 0x1234 / 0x0F0F -> out_valid two cycles after accept with out_a = 0x1234, out_b = 0x0F0F, out_c = 0, rd_addr_b = {3,1}, rd_blk_b = 1.
- Instr1 writes ch 5, instr2 reads ch 5 -> instr2 stalls in S_CHECK until cycle after wb_ch_valid with dest 5; instr2 out_valid follows.
- out_ready held low 4 cycles -> out_* stable; in_ready = 0; next instr accepted on the same cycle out_ready rises.
- wb_ch_valid dest 7 on the same cycle a new instr issues with dest 7 -> pend_ch[7] remains 1.
- reset_n pulsed low mid-S_READ -> out_valid = 0 immediately and scoreboard clear; a new instr after release completes normally.
- With OPERAND_FETCH_STALL_COUNT_EN: 10 stall cycles -> stall_cycles = 10; sample_tick -> 0.
